// File: rtl/apb_arbiter_master_if.sv
// rtl/apb_arbiter_master_if.sv - requester and APB signal bundle for apb_arbiter_master
interface apb_arbiter_master_if;
   // requester 0
   logic       req0_valid;
   logic       req0_write;
   logic [7:0] req0_addr;
   logic [7:0] req0_wdata;
   logic       req0_done;
   // requester 1
   logic       req1_valid;
   logic       req1_write;
   logic [7:0] req1_addr;
   logic [7:0] req1_wdata;
   logic       req1_done;
   // shared completion status
   logic [7:0] rdata;
   logic       err;
   // APB master side
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;

   modport master (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      output req0_done,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req1_done,
      output rdata, err,
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready
   );

   modport slave (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      input  req0_done,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req1_done,
      input  rdata, err,
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready
   );
endinterface

// File: rtl/apb_arbiter_master.sv
// rtl/apb_arbiter_master.sv - two-requester round-robin APB master with access timeout
module apb_arbiter_master #(
   parameter logic [3:0] TIMEOUT = 4'd15
) (
   input logic                  pclk,
   input logic                  presetn,
   apb_arbiter_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] acc_cnt;
   logic       last_grant;   // index of the requester granted most recently
   logic       elig0;
   logic       elig1;
   logic       grant_nxt;
   logic       grant_now;
   logic       complete;
   logic       timeout;

   // A requester whose done is pulsing this cycle is finishing, not asking again.
   assign elig0     = bus.req0_valid & ~bus.req0_done;
   assign elig1     = bus.req1_valid & ~bus.req1_done;
   assign grant_now = (state == IDLE) & (elig0 | elig1);
   assign complete  = (state == ACCESS) & bus.pready;
   assign timeout   = (state == ACCESS) & ~bus.pready & (acc_cnt == TIMEOUT);

   // Round-robin choice: on contention favour whoever was not served last.
   always_comb begin
      grant_nxt = 1'b0;
      if (elig0 && elig1) begin
         grant_nxt = ~last_grant;
      end else if (elig1) begin
         grant_nxt = 1'b1;
      end
   end

   // State register; reset drops the bus immediately.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and APB phase controls.
   always_comb begin
      state_nxt   = state;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      case (state)
         IDLE: begin
            if (elig0 || elig1) begin
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            bus.psel  = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            bus.psel    = 1'b1;
            bus.penable = 1'b1;
            if (complete || timeout) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture the winner's command at the grant edge and hold it for the transfer.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         last_grant <= 1'b1;
         bus.pwrite <= 1'b0;
         bus.paddr  <= 8'h00;
         bus.pwdata <= 8'h00;
      end else if (grant_now) begin
         last_grant <= grant_nxt;
         bus.pwrite <= grant_nxt ? bus.req1_write : bus.req0_write;
         bus.paddr  <= grant_nxt ? bus.req1_addr  : bus.req0_addr;
         bus.pwdata <= grant_nxt ? bus.req1_wdata : bus.req0_wdata;
      end
   end

   // Count ACCESS cycles spent waiting on pready; cleared as ACCESS is entered.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         acc_cnt <= 4'd0;
      end else if (state == SETUP) begin
         acc_cnt <= 4'd0;
      end else if ((state == ACCESS) && !bus.pready && (acc_cnt != TIMEOUT)) begin
         acc_cnt <= acc_cnt + 4'd1;
      end
   end

   // Completion: one-cycle done to the granted requester, err marks a timeout abort.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         bus.req0_done <= 1'b0;
         bus.req1_done <= 1'b0;
         bus.err       <= 1'b0;
         bus.rdata     <= 8'h00;
      end else begin
         bus.req0_done <= (complete | timeout) & ~last_grant;
         bus.req1_done <= (complete | timeout) & last_grant;
         bus.err       <= timeout & ~complete;
         if (complete && !bus.pwrite) begin
            bus.rdata <= bus.prdata;
         end
      end
   end

endmodule

// File: tb/tb_apb_arbiter_master.sv
// tb/tb_apb_arbiter_master.sv - randomized bench with transaction-level reference model
module tb_apb_arbiter_master;

   localparam int TO = 15;

   logic pclk;
   logic presetn;
   int   n_checks;
   int   n_errors;

   apb_arbiter_master_if bus ();

   apb_arbiter_master #(.TIMEOUT(4'd15)) dut (
      .pclk   (pclk),
      .presetn(presetn),
      .bus    (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: a transfer is "busy" from grant; k counts cycles since
   // grant (1 = setup cycle, 2.. = access cycles, k-2 of which have waited).
   bit         m_busy;
   int         m_k;
   int         m_g;
   int         m_last;
   logic       m_write;
   logic [7:0] m_addr;
   logic [7:0] m_wdata;
   logic [7:0] m_rdata;
   logic       m_done0;
   logic       m_done1;
   logic       m_err;
   bit         m_e0;
   bit         m_e1;

   always @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         m_busy = 0; m_k = 0; m_g = 0; m_last = 1;
         m_write = 0; m_addr = 8'h00; m_wdata = 8'h00; m_rdata = 8'h00;
         m_done0 = 0; m_done1 = 0; m_err = 0;
      end else begin
         m_e0 = bus.req0_valid && !m_done0;
         m_e1 = bus.req1_valid && !m_done1;
         m_done0 = 0; m_done1 = 0; m_err = 0;
         if (!m_busy) begin
            if (m_e0 || m_e1) begin
               m_g     = (m_e0 && m_e1) ? (1 - m_last) : (m_e0 ? 0 : 1);
               m_last  = m_g;
               m_write = (m_g == 1) ? bus.req1_write : bus.req0_write;
               m_addr  = (m_g == 1) ? bus.req1_addr  : bus.req0_addr;
               m_wdata = (m_g == 1) ? bus.req1_wdata : bus.req0_wdata;
               m_busy  = 1;
               m_k     = 1;
            end
         end else if (m_k == 1) begin
            m_k = 2;
         end else if (bus.pready || (m_k - 2 == TO)) begin
            if (bus.pready && !m_write) m_rdata = bus.prdata;
            m_err   = !bus.pready;
            m_done0 = (m_g == 0);
            m_done1 = (m_g == 1);
            m_busy  = 0;
         end else begin
            m_k++;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge pclk) begin
      check("psel",      bus.psel,      m_busy);
      check("penable",   bus.penable,   m_busy && m_k >= 2);
      check("pwrite",    bus.pwrite,    m_write);
      check("paddr",     bus.paddr,     m_addr);
      check("pwdata",    bus.pwdata,    m_wdata);
      check("rdata",     bus.rdata,     m_rdata);
      check("req0_done", bus.req0_done, m_done0);
      check("req1_done", bus.req1_done, m_done1);
      check("err",       bus.err,       m_err);
   end

   int  cnt;
   int  idle_run;
   int  ng;
   int  stall;
   bit  seen;
   int  grants[4];

   initial begin
      n_checks = 0; n_errors = 0;
      presetn = 1'b0;
      bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
      bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
      bus.prdata = 8'h00; bus.pready = 1'b0;

      // reset values
      repeat (2) @(negedge pclk);
      check("rst_psel", bus.psel, 1'b0);
      check("rst_penable", bus.penable, 1'b0);
      check("rst_paddr", bus.paddr, 8'h00);
      check("rst_rdata", bus.rdata, 8'h00);
      check("rst_done", {bus.req0_done, bus.req1_done, bus.err}, 3'b000);
      #2 presetn = 1'b1;

      // single write
      @(negedge pclk);
      bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 8'h10; bus.req0_wdata = 8'hA5;
      bus.pready = 1;
      @(negedge pclk);
      check("wr_setup_psel", bus.psel, 1'b1);
      check("wr_setup_penable", bus.penable, 1'b0);
      check("wr_paddr", bus.paddr, 8'h10);
      check("wr_pwdata", bus.pwdata, 8'hA5);
      @(negedge pclk);
      check("wr_access_penable", bus.penable, 1'b1);
      check("wr_done_early", bus.req0_done, 1'b0);
      @(negedge pclk);
      check("wr_done", bus.req0_done, 1'b1);
      check("wr_err", bus.err, 1'b0);
      check("wr_idle_psel", bus.psel, 1'b0);
      bus.req0_valid = 0;

      // read-back by requester 1
      bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 8'h10; bus.prdata = 8'hA5;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge pclk);
         seen = bus.req1_done;
      end
      check("rd_done_seen", seen, 1'b1);
      check("rd_rdata", bus.rdata, 8'hA5);
      check("rd_err", bus.err, 1'b0);
      bus.req1_valid = 0;

      // timeout
      bus.pready = 0; bus.prdata = 8'h5A;
      bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 8'h33;
      seen = 0; cnt = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge pclk);
         if (bus.penable) cnt++;
         seen = bus.req0_done;
      end
      check("to_done_seen", seen, 1'b1);
      check("to_access_cycles", cnt[7:0], 8'd16);
      check("to_err", bus.err, 1'b1);
      check("to_rdata_kept", bus.rdata, 8'hA5);
      bus.req0_valid = 0;

      // normal transfer after timeout
      bus.pready = 1;
      bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 8'h44; bus.req1_wdata = 8'h77;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge pclk);
         seen = bus.req1_done;
      end
      check("post_to_done_seen", seen, 1'b1);
      check("post_to_err", bus.err, 1'b0);
      bus.req1_valid = 0;

      // contention: grants alternate, one idle cycle before each setup
      bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 8'h01;
      bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 8'h02;
      ng = 0; idle_run = 0;
      for (int i = 0; i < 60 && ng < 4; i++) begin
         @(negedge pclk);
         if (!bus.psel) begin
            idle_run++;
         end else begin
            if (!bus.penable) begin
               grants[ng] = (bus.paddr == 8'h02) ? 1 : 0;
               if (ng > 0) check("rr_idle_gap", idle_run[7:0], 8'd1);
               ng++;
            end
            idle_run = 0;
         end
      end
      check("rr_grants_seen", ng[7:0], 8'd4);
      check("rr_order", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]}, 4'b0101);
      bus.req0_valid = 0; bus.req1_valid = 0;
      repeat (6) @(negedge pclk);

      // reset during ACCESS
      bus.pready = 0;
      bus.req0_valid = 1; bus.req0_addr = 8'h55;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge pclk);
         seen = bus.penable;
      end
      check("rst_mid_access_seen", seen, 1'b1);
      #1 presetn = 0;
      #1;
      check("rst_mid_psel", bus.psel, 1'b0);
      check("rst_mid_penable", bus.penable, 1'b0);
      bus.req1_valid = 1; bus.req1_addr = 8'h66;
      @(negedge pclk);
      check("rst_mid_no_done", {bus.req0_done, bus.req1_done}, 2'b00);
      #2 presetn = 1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge pclk);
         seen = bus.psel;
      end
      check("rst_first_grant", bus.paddr, 8'h55);
      bus.pready = 1;
      bus.req0_valid = 0; bus.req1_valid = 0;
      repeat (4) @(negedge pclk);

      // randomized traffic against the model
      stall = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge pclk);
         if (m_done0) begin
            if ($urandom_range(0, 3) != 0) bus.req0_valid = 0;
         end else if (!bus.req0_valid) begin
            if ($urandom_range(0, 2) == 0) begin
               bus.req0_valid = 1;
               bus.req0_write = 1'($urandom_range(0, 1));
               bus.req0_addr  = 8'($urandom);
               bus.req0_wdata = 8'($urandom);
            end
         end else if (m_busy && m_g == 0 && $urandom_range(0, 19) == 0) begin
            bus.req0_valid = 0;
         end
         if (m_done1) begin
            if ($urandom_range(0, 3) != 0) bus.req1_valid = 0;
         end else if (!bus.req1_valid) begin
            if ($urandom_range(0, 2) == 0) begin
               bus.req1_valid = 1;
               bus.req1_write = 1'($urandom_range(0, 1));
               bus.req1_addr  = 8'($urandom);
               bus.req1_wdata = 8'($urandom);
            end
         end else if (m_busy && m_g == 1 && $urandom_range(0, 19) == 0) begin
            bus.req1_valid = 0;
         end
         if (stall > 0) begin
            bus.pready = 0;
            stall--;
         end else begin
            if ($urandom_range(0, 59) == 0) stall = 20;
            bus.pready = ($urandom_range(0, 2) != 0);
         end
         bus.prdata = 8'($urandom);
         if (c == 1000 || c == 2200) begin
            #2 presetn = 0;
            @(negedge pclk);
            #2 presetn = 1;
         end
      end

      bus.req0_valid = 0; bus.req1_valid = 0;
      repeat (3) @(negedge pclk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb_arbiter_master.md
APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 Parameter TIMEOUT, default 4'd15, is the maximum number of ACCESS cycles allowed without pready before the transfer is aborted.
REQ-002 pclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 presetn  input  1  reset, asynchronous assert, active-low; deasserts synchronously to pclk.
REQ-004 req0_valid  input  1  requester 0 transfer request; held high until req0_done.
REQ-005 req0_write  input  1  requester 0 direction (1 = write, 0 = read); stable while req0_valid is high.
REQ-006 req0_addr  input  8  requester 0 address; stable while req0_valid is high.
REQ-007 req0_wdata  input  8  requester 0 write data; stable while req0_valid is high.
REQ-008 req0_done  output  1  one-cycle completion pulse to requester 0.
REQ-009 req1_valid, req1_write, req1_addr[7:0], req1_wdata[7:0] (inputs) and req1_done (output) are identical in meaning to REQ-004..REQ-008, for requester 1.
REQ-010 rdata  output  8  read data of the last completed read.
REQ-011 err  output  1  valid with any doneN pulse; 1 = timeout abort.
REQ-012 psel, penable, pwrite  output  1 each  APB master controls.
REQ-013 paddr, pwdata  output  8 each  APB address and write data.
REQ-014 prdata  input  8  APB read data.
REQ-015 pready  input  1  APB transfer-complete flag.

Function
REQ-016 FSM states: IDLE (psel=0, penable=0), SETUP (psel=1, penable=0), ACCESS (psel=1, penable=1).
REQ-017 IDLE -> SETUP when at least one eligible request is present; otherwise stay in IDLE.
REQ-018 SETUP -> ACCESS unconditionally after exactly one cycle.
REQ-019 ACCESS -> IDLE when pready=1 (normal completion) or on timeout (REQ-025); otherwise stay in ACCESS.
REQ-020 A request is eligible when reqN_valid=1 and reqN_done=0 in the same cycle; this prevents re-granting a request that is just completing.
REQ-021 Arbitration happens only in IDLE, round-robin: if both are eligible, grant the requester not granted last. After reset, requester 0 has priority.
REQ-022 On the grant edge (IDLE->SETUP), register the grant index, pwrite, paddr and pwdata from the granted requester; hold them constant through SETUP and ACCESS.
REQ-023 Normal completion: at the edge where state=ACCESS and pready=1:
  - pulse the granted reqN_done for exactly one cycle, with err=0;
  - for a read, load rdata from prdata at the same edge; for a write, leave rdata unchanged.
REQ-024 The ACCESS cycle counter clears on entry to ACCESS and increments once per ACCESS cycle with pready=0.
REQ-025 Timeout: when the counter reaches TIMEOUT with pready=0, go to IDLE, pulse reqN_done with err=1, and leave rdata unchanged.
REQ-026 pready=1 on the same edge as timeout: completion wins (err=0).
REQ-027 pready is ignored in IDLE and SETUP.
REQ-028 Minimum gap between transfers is one IDLE cycle; a back-to-back request reaches SETUP 2 cycles after the previous done edge.
REQ-029 At most one doneN is high in any cycle; err is 0 whenever no done is high.
REQ-030 Deasserting reqN_valid while granted has no effect; the transfer completes and done still pulses.

Reset
REQ-031 While presetn=0:
  - state=IDLE;
  - psel, penable, pwrite, req0_done, req1_done, err all 0;
  - paddr, pwdata, rdata all 8'h00;
  - counter 0; round-robin priority set to requester 0.
REQ-032 Reset asserted mid-transfer forces IDLE immediately (asynchronously); no done is generated for the aborted transfer.

Verification
REQ-033 Single write: req0 write addr 8'h10, data 8'hA5, pready=1 in the first ACCESS cycle -> psel rises 1 cycle after valid, penable 1 cycle later; req0_done=1 with err=0 at the next edge.
REQ-034 Read-back: req1 read addr 8'h10 after REQ-033 -> rdata=8'hA5 on req1_done, err=0.
REQ-035 Contention: req0 and req1 both valid out of reset, held after done -> grants alternate 0,1,0,1; each SETUP is preceded by exactly one IDLE cycle.
REQ-036 Wait states: pready held 0 for 2 ACCESS cycles -> ACCESS lasts 3 cycles; paddr, pwdata and pwrite are stable throughout.
REQ-037 Timeout: pready never asserted, TIMEOUT=15 -> done with err=1 after 16 ACCESS cycles; rdata unchanged; next request proceeds normally.
REQ-038 Reset in ACCESS: presetn pulled low -> psel=penable=0 immediately, no done; first post-reset grant goes to req0.
